// File: rtl/quan_stage.sv
// quan_stage -- quantization stage of the frame pipeline.
//
// Answers the controller's start/finish handshake. After a start pulse it reads
// one frame of coefficients from coefficient RAM. Each coefficient is rounded,
// right-shifted by a per-frame amount and saturated. The results go to
// quantized-sample RAM. A sticky finish flag tells the controller the frame is
// complete.
//
// Ports:
//   clk_in        system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rstn_quan     controller soft reset, active-low, sampled on clk_in
//   start_quan    one-cycle frame start pulse
//   qshift        quantization shift, latched when a frame starts
//   finish_quan   frame complete (sticky until the next start or reset)
//   busy          frame in progress
//   coef_rd_en    coefficient RAM read enable
//   coef_rd_addr  coefficient RAM read address (0 while not reading)
//   coef_rd_data  coefficient RAM data, valid one cycle after the read
//   q_wr_en       quantized RAM write enable
//   q_wr_addr     quantized RAM write address (0 while not writing)
//   q_wr_data     quantized sample (holds its value between writes)
//   sat_cnt       saturated samples in the last or current frame
module quan_stage #(
  parameter int N_COEF  = 256,
  parameter int ADDR_W  = 8,
  parameter int IN_W    = 24,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               rstn_quan,
  input  logic               start_quan,
  input  logic [SHIFT_W-1:0] qshift,
  output logic               finish_quan,
  output logic               busy,
  output logic               coef_rd_en,
  output logic [ADDR_W-1:0]  coef_rd_addr,
  input  logic [IN_W-1:0]    coef_rd_data,
  output logic               q_wr_en,
  output logic [ADDR_W-1:0]  q_wr_addr,
  output logic [OUT_W-1:0]   q_wr_data,
  output logic [ADDR_W:0]    sat_cnt
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(IN_W - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_COEF - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   rd_addr;
  logic                drain_cnt;
  logic [SHIFT_W-1:0]  shift_reg;
  logic                start_ok;
  logic                last_rd;

  // Data-return stage: valid flag and address of the sample on coef_rd_data.
  logic                v1;
  logic [ADDR_W-1:0]   a1;

  logic signed [IN_W:0] x_ext, rnd, sum, r;
  logic                 sat_hi, sat_lo;
  logic [OUT_W-1:0]     q;

  // A start is accepted only in IDLE or DONE. A start pulse while busy is ignored.
  assign start_ok = start_quan && (state == IDLE || state == DONE);
  assign last_rd  = (rd_addr == LAST_ADDR);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else if (!rstn_quan)
      state <= IDLE;
    else
      state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_quan) state_next = READ;
      READ:    if (last_rd) state_next = DRAIN;
      // The last sample needs two cycles to leave the pipeline.
      DRAIN:   if (drain_cnt) state_next = DONE;
      DONE:    if (start_quan) state_next = READ;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    coef_rd_en  = 1'b0;
    busy        = 1'b0;
    finish_quan = 1'b0;
    case (state)
      READ:    begin coef_rd_en = 1'b1; busy = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    finish_quan = 1'b1;
      default: ;
    endcase
  end

  assign coef_rd_addr = rd_addr;

  // ---------------- control counters and shift latch ----------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
      shift_reg <= '0;
    end else if (!rstn_quan) begin
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
      shift_reg <= '0;
    end else begin
      // The read address is zero outside READ, so it can drive the port directly.
      if (state == READ && !last_rd)
        rd_addr <= rd_addr + ADDR_W'(1);
      else
        rd_addr <= '0;

      if (state == DRAIN)
        drain_cnt <= ~drain_cnt;
      else
        drain_cnt <= 1'b0;

      // Shifts beyond IN_W-1 add nothing, so clamp once at latch time.
      if (start_ok)
        shift_reg <= (qshift > MAX_SHIFT) ? MAX_SHIFT : qshift;
    end
  end

  // ---------------- quantizer arithmetic ----------------
  // The extra bit keeps x + 2^(s-1) from overflowing at the positive limit.
  always_comb begin
    x_ext = $signed({coef_rd_data[IN_W-1], coef_rd_data});
    if (shift_reg == '0)
      rnd = '0;
    else
      rnd = (IN_W+1)'(1) << (shift_reg - SHIFT_W'(1));
    sum = x_ext + rnd;
    r   = sum >>> shift_reg;
    // r fits in OUT_W bits exactly when all bits above the output sign bit
    // copy the sign.
    sat_hi = ~r[IN_W] & (|r[IN_W-1:OUT_W-1]);
    sat_lo = r[IN_W] & ~(&r[IN_W-1:OUT_W-1]);
    if (sat_hi)
      q = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo)
      q = {1'b1, {(OUT_W-1){1'b0}}};
    else
      q = r[OUT_W-1:0];
  end

  // ---------------- datapath pipeline ----------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      a1        <= '0;
      q_wr_en   <= 1'b0;
      q_wr_addr <= '0;
      q_wr_data <= '0;
      sat_cnt   <= '0;
    end else if (!rstn_quan) begin
      v1        <= 1'b0;
      a1        <= '0;
      q_wr_en   <= 1'b0;
      q_wr_addr <= '0;
      q_wr_data <= '0;
      sat_cnt   <= '0;
    end else begin
      v1        <= coef_rd_en;
      a1        <= coef_rd_addr;
      q_wr_en   <= v1;
      q_wr_addr <= v1 ? a1 : '0;
      if (v1)
        q_wr_data <= q;
      // A start is only accepted after the pipeline has drained, so a clear
      // and a count never fall in the same cycle.
      if (start_ok)
        sat_cnt <= '0;
      else if (v1 && (sat_hi || sat_lo))
        sat_cnt <= sat_cnt + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_quan_stage.sv
// Testbench for quan_stage. It models both RAMs. It runs directed frames and
// checks cycle-accurate handshake timing, quantized values and sat_cnt.
module tb_quan_stage;

  localparam int N = 256;

  logic        clk_in = 1'b0;
  logic        rst_n, rstn_quan, start_quan;
  logic [4:0]  qshift;
  logic        finish_quan, busy, coef_rd_en, q_wr_en;
  logic [7:0]  coef_rd_addr, q_wr_addr;
  logic [23:0] rd_data;
  logic [15:0] q_wr_data;
  logic [8:0]  sat_cnt;

  logic [23:0] coef_mem [0:N-1];
  logic [15:0] q_mem    [0:N-1];
  int          wr_tag   [0:N-1];
  logic [15:0] exp_q    [0:N-1];

  int frame_id = 0;
  int rd_total = 0;
  int wr_total = 0;
  int checks   = 0;
  int errors   = 0;

  typedef struct {
    logic [4:0] sh;
    int         coef;
    int         q;
    bit         sat;
  } vec_t;
  vec_t vecs [16];

  always #5 clk_in = ~clk_in;

  quan_stage dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .rstn_quan    (rstn_quan),
    .start_quan   (start_quan),
    .qshift       (qshift),
    .finish_quan  (finish_quan),
    .busy         (busy),
    .coef_rd_en   (coef_rd_en),
    .coef_rd_addr (coef_rd_addr),
    .coef_rd_data (rd_data),
    .q_wr_en      (q_wr_en),
    .q_wr_addr    (q_wr_addr),
    .q_wr_data    (q_wr_data),
    .sat_cnt      (sat_cnt)
  );

  // RAM models: registered coefficient read, quantized write with frame tag.
  always @(posedge clk_in) begin
    if (coef_rd_en) begin
      rd_data  <= coef_mem[coef_rd_addr];
      rd_total <= rd_total + 1;
    end
    if (q_wr_en) begin
      q_mem[q_wr_addr]  <= q_wr_data;
      wr_tag[q_wr_addr] <= frame_id;
      wr_total          <= wr_total + 1;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Start a frame and follow it for 260 cycles. Cycle t+k is observed at the
  // k-th falling edge after the edge that samples start.
  task automatic run_frame(input string name, input logic [4:0] sh,
                           input int busy_k, input logic [4:0] busy_sh);
    int   fin_k, bad, w0, e_ra, e_wa;
    logic e_rd, e_wr, e_busy, e_fin;
    frame_id++;
    w0    = wr_total;
    fin_k = -1;
    bad   = 0;
    @(negedge clk_in);
    start_quan = 1'b1;
    qshift     = sh;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk_in);
      if (k == 1) start_quan = 1'b0;
      if (busy_k > 0 && k == busy_k) begin start_quan = 1'b1; qshift = busy_sh; end
      if (busy_k > 0 && k == busy_k + 1) start_quan = 1'b0;
      e_rd   = (k <= N);
      e_ra   = e_rd ? k - 1 : 0;
      e_wr   = (k >= 3 && k <= N + 2);
      e_wa   = e_wr ? k - 3 : 0;
      e_busy = (k <= N + 2);
      e_fin  = (k >= N + 3);
      if (busy !== e_busy || finish_quan !== e_fin || coef_rd_en !== e_rd ||
          coef_rd_addr !== 8'(e_ra) || q_wr_en !== e_wr || q_wr_addr !== 8'(e_wa)) begin
        if (bad == 0)
          $display("FAIL %s timing at t+%0d: busy=%0b fin=%0b rd=%0b/%0d wr=%0b/%0d required busy=%0b fin=%0b rd=%0b/%0d wr=%0b/%0d",
                   name, k, busy, finish_quan, coef_rd_en, coef_rd_addr, q_wr_en, q_wr_addr,
                   e_busy, e_fin, e_rd, e_ra, e_wr, e_wa);
        bad++;
      end
      if (finish_quan === 1'b1 && fin_k < 0) fin_k = k;
    end
    check({name, " timing errors"}, bad, 0);
    check({name, " finish cycle"}, fin_k, N + 3);
    check({name, " write count"}, wr_total - w0, N);
  endtask

  task automatic check_q(input string name, input int exp_sat);
    int bad, first;
    bad   = 0;
    first = -1;
    for (int i = 0; i < N; i++) begin
      if (wr_tag[i] != frame_id || q_mem[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s samples: %0d bad, first addr %0d actual=%0d required=%0d",
               name, bad, first, $signed(q_mem[first]), $signed(exp_q[first]));
    end
    check({name, " sat_cnt"}, sat_cnt, exp_sat);
  endtask

  task automatic fill(input int coef, input int q);
    for (int i = 0; i < N; i++) begin
      coef_mem[i] = 24'(coef);
      exp_q[i]    = 16'(q);
    end
  endtask

  initial begin
    int r0, w0;
    vecs[0]  = '{5'd4,  8,        1,      1'b0};
    vecs[1]  = '{5'd4,  7,        0,      1'b0};
    vecs[2]  = '{5'd4,  -8,       0,      1'b0};
    vecs[3]  = '{5'd4,  -9,       -1,     1'b0};
    vecs[4]  = '{5'd4,  24,       2,      1'b0};
    vecs[5]  = '{5'd0,  40000,    32767,  1'b1};
    vecs[6]  = '{5'd0,  -40000,   -32768, 1'b1};
    vecs[7]  = '{5'd0,  32767,    32767,  1'b0};
    vecs[8]  = '{5'd0,  -32768,   -32768, 1'b0};
    vecs[9]  = '{5'd31, 8388607,  1,      1'b0};
    vecs[10] = '{5'd31, -8388608, -1,     1'b0};
    vecs[11] = '{5'd8,  8388607,  32767,  1'b1};
    vecs[12] = '{5'd8,  -8388608, -32768, 1'b0};
    vecs[13] = '{5'd1,  -3,       -1,     1'b0};
    vecs[14] = '{5'd23, 4194304,  1,      1'b0};
    vecs[15] = '{5'd24, 4194304,  1,      1'b0};

    rst_n      = 1'b0;
    rstn_quan  = 1'b1;
    start_quan = 1'b0;
    qshift     = '0;
    fill(0, 0);
    repeat (3) @(negedge clk_in);
    check("reset busy", busy, 0);
    check("reset finish", finish_quan, 0);
    check("reset rd_en", coef_rd_en, 0);
    check("reset rd_addr", coef_rd_addr, 0);
    check("reset wr_en", q_wr_en, 0);
    check("reset wr_addr", q_wr_addr, 0);
    check("reset wr_data", q_wr_data, 0);
    check("reset sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Identity frame: qshift 0, coef[i] = i-128.
    for (int i = 0; i < N; i++) begin
      coef_mem[i] = 24'(i - 128);
      exp_q[i]    = 16'(i - 128);
    end
    run_frame("identity", 5'd0, 0, 5'd0);
    check_q("identity", 0);

    // Second start at t+50 with a different shift must change nothing.
    run_frame("start while busy", 5'd0, 50, 5'd4);
    check_q("start while busy", 0);

    // Uniform frames from the vector table; saturating vectors count every sample.
    foreach (vecs[v]) begin
      fill(vecs[v].coef, vecs[v].q);
      run_frame($sformatf("vec%0d sh=%0d x=%0d", v, vecs[v].sh, vecs[v].coef),
                vecs[v].sh, 0, 5'd0);
      check_q($sformatf("vec%0d", v), vecs[v].sat ? N : 0);
    end

    // Mixed saturation frame.
    fill(0, 0);
    coef_mem[0] = 24'(40000);  exp_q[0] = 16'(32767);
    coef_mem[1] = 24'(-40000); exp_q[1] = 16'(-32768);
    coef_mem[2] = 24'(32767);  exp_q[2] = 16'(32767);
    coef_mem[3] = 24'(-32768); exp_q[3] = 16'(-32768);
    run_frame("mixed sat", 5'd0, 0, 5'd0);
    check_q("mixed sat", 2);

    // Back-to-back frames: the second frame starts from DONE.
    fill(40000, 32767);
    run_frame("b2b first", 5'd0, 0, 5'd0);
    check_q("b2b first", N);
    check("b2b finish held", finish_quan, 1);
    fill(40000, 156);
    run_frame("b2b second", 5'd8, 0, 5'd0);
    check_q("b2b second", 0);

    // Soft reset in cycle t+100 of a saturating frame.
    fill(40000, 32767);
    frame_id++;
    @(negedge clk_in);
    start_quan = 1'b1;
    qshift     = 5'd0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk_in);
      if (k == 1) start_quan = 1'b0;
    end
    check("srst sat before", sat_cnt, 98);
    rstn_quan = 1'b0;
    @(negedge clk_in);
    rstn_quan = 1'b1;
    r0 = rd_total;
    w0 = wr_total;
    check("srst busy", busy, 0);
    check("srst finish", finish_quan, 0);
    check("srst rd_en", coef_rd_en, 0);
    check("srst wr_en", q_wr_en, 0);
    check("srst sat_cnt", sat_cnt, 0);
    check("srst wr_data", q_wr_data, 0);
    repeat (20) @(negedge clk_in);
    check("srst reads after", rd_total - r0, 0);
    check("srst writes after", wr_total - w0, 0);
    check("srst idle finish", finish_quan, 0);

    // Soft reset wins over a simultaneous start.
    start_quan = 1'b1;
    rstn_quan  = 1'b0;
    @(negedge clk_in);
    start_quan = 1'b0;
    rstn_quan  = 1'b1;
    repeat (3) @(negedge clk_in);
    check("srst priority busy", busy, 0);
    check("srst priority reads", rd_total - r0, 0);

    run_frame("after srst", 5'd0, 0, 5'd0);
    check_q("after srst", N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quan_stage.md
Name: quan_stage

Overview:
- Responder side of the pipeline-controller start/finish handshake for the quantization stage.
- Accepts a one-cycle start pulse from the process controller and reads one MDCT frame of coefficients from coefficient RAM.
- Quantizes each coefficient with a shared right-shift, rounding and saturation, then writes the results to quantized-sample RAM.
- Raises a sticky finish flag back to the controller when the frame is complete.

Parameters:
- N_COEF, 256, coefficients per frame (power of two).
- ADDR_W, 8, RAM address width, log2(N_COEF).
- IN_W, 24, signed coefficient width.
- OUT_W, 16, signed quantized-sample width.
- SHIFT_W, 5, width of the quantization shift input.

Ports:
- clk_in  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rstn_quan  in  1  controller soft reset, active-low, sampled synchronously.
- start_quan  in  1  frame start pulse from the controller; one cycle wide.
- qshift  in  SHIFT_W  quantization shift, latched at start.
- finish_quan  out  1  frame done; sticky level.
- busy  out  1  high while a frame is in progress.
- coef_rd_en  out  1  coefficient RAM read enable.
- coef_rd_addr  out  ADDR_W  coefficient RAM read address.
- coef_rd_data  in  IN_W  coefficient RAM data; valid 1 cycle after coef_rd_en.
- q_wr_en  out  1  quantized RAM write enable.
- q_wr_addr  out  ADDR_W  quantized RAM write address.
- q_wr_data  out  OUT_W  quantized sample.
- sat_cnt  out  ADDR_W+1  number of saturated samples in the last or current frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - All outputs are 0, including finish_quan, busy, rd/wr enables, addresses, q_wr_data and sat_cnt.
- Soft reset (rstn_quan low at a rising edge):
  - Same effect as rst_n, applied on that edge.
  - Takes priority over start_quan.
  - Aborts a frame in progress; no further RAM accesses follow.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on start_quan=1, latch qshift, clear sat_cnt and finish_quan, go to READ.
- READ:
  - coef_rd_en=1 with coef_rd_addr = 0,1,...,N_COEF-1, one address per cycle.
  - After issuing address N_COEF-1, go to DRAIN.
- Datapath: 2-stage pipeline.
  - Data arrives 1 cycle after the read.
  - The registered result is written 1 cycle after data arrives, so q_wr_addr for a sample equals that sample's read address delayed by 2 cycles.
- DRAIN: held for 2 cycles until the last write has been issued, then go to DONE.
- DONE: finish_quan=1 and busy=0; stays until start_quan or soft reset.
  - start_quan in DONE clears finish_quan on the next edge and begins a new frame (same as from IDLE).
- Timing, with start sampled at edge t:
  - busy=1 from t+1 until finish rises.
  - Reads occur in cycles t+1..t+N_COEF.
  - Writes occur in cycles t+3..t+N_COEF+2.
  - finish_quan rises at edge t+N_COEF+3.
- start_quan while busy (READ/DRAIN) is ignored; no restart, no qshift relatch.
- Arithmetic, with s = latched qshift clamped to IN_W-1:
  - Compute in IN_W+1-bit signed.
  - If s>0: r = (x + 2^(s-1)) >>> s (arithmetic shift; rounds half toward +inf).
  - If s=0: r = x.
  - If r > 2^(OUT_W-1)-1 then q = 2^(OUT_W-1)-1, else if r < -2^(OUT_W-1) then q = -2^(OUT_W-1), else q = r.
  - Each saturated sample increments sat_cnt. sat_cnt maximum is N_COEF, so it cannot wrap.
- q_wr_data holds its last value when q_wr_en=0.
- coef_rd_addr and q_wr_addr return to 0 when their enable is low.

Test Plan:
- Identity frame: qshift=0, coef[i]=i-128 -> 256 writes with q[i]=i-128, sat_cnt=0, finish_quan high exactly at t+259, busy low at the same edge.
- Rounding: qshift=4 with coef values 8, 7, -8, -9, 24 -> q = 1, 0, 0, -1, 2.
- Saturation: qshift=0 with coef values 40000, -40000, 32767, -32768 -> q = 32767, -32768, 32767, -32768; sat_cnt=2. qshift=31 is clamped to 23; coef 2^23-1 -> 1.
- Start while busy: second start_quan at t+50 -> ignored; exactly 256 writes; finish_quan at t+259.
- Soft reset mid-frame: rstn_quan low at t+100 for 1 cycle -> no RAM access after that edge; finish_quan=0, sat_cnt=0, state IDLE. A subsequent start completes a normal frame.
- Back-to-back frames: start in DONE -> finish_quan falls next edge, new frame runs with the new qshift, finish_quan rises 259 cycles after the second start; sat_cnt reflects only the second frame.
